// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter (start, 8 data bits LSB first, stop) with a status word.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_tx_fifo #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned DWIDTH     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wreq_i,
   input  logic [7:0]        wdat_i,
   input  logic [0:0]        wstr_i,
   output logic              werr_o,
   input  logic              rreq_i,
   output logic [DWIDTH-1:0] rdat_o,
   output logic              rerr_o,
   input  logic [15:0]       div_i,
   input  logic              tx_en_i,
   output logic              tx_o
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned LW = AW + 1;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_TX_PARITY_EN
      StParity,
`endif
      StStop
   } state_e;

   // FIFO storage and bookkeeping
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;

   // Transmitter state
   state_e      r_state;
   state_e      w_state_d;
   logic [15:0] r_div;
   logic [15:0] w_div_d;
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_d;
   logic [2:0]  r_bit;
   logic [2:0]  w_bit_d;
   logic [7:0]  r_data;
   logic [7:0]  w_data_d;
   logic        r_tx;
   logic        w_tx_d;
   logic        w_bit_end;
   logic        w_start;
   logic        w_unused;

   // Full is taken from the registered level, so a same-cycle pop never frees a slot.
   assign w_full  = (r_level == LW'(FIFO_DEPTH));
   assign w_empty = (r_level == '0);
   assign w_push  = wreq_i & wstr_i[0] & ~w_full;
   assign werr_o  = wreq_i & wstr_i[0] & w_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_mem[r_wr_ptr] <= wdat_i;
      end
   end

   assign w_bit_end = (r_cnt == r_div);

   always_comb begin
      w_state_d = r_state;
      w_div_d   = r_div;
      w_cnt_d   = r_cnt + 16'd1;
      w_bit_d   = r_bit;
      w_data_d  = r_data;
      w_tx_d    = r_tx;
      w_start   = 1'b0;
      w_pop     = 1'b0;

      unique case (r_state)
         StIdle: begin
            w_cnt_d = '0;
            w_tx_d  = 1'b1;
            w_start = tx_en_i & ~w_empty;
         end
         StStart: begin
            if (w_bit_end) begin
               w_state_d = StData;
               w_cnt_d   = '0;
               w_bit_d   = '0;
               w_tx_d    = r_data[0];
            end
         end
         StData: begin
            if (w_bit_end) begin
               w_cnt_d = '0;
               if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  w_state_d = StParity;
                  w_tx_d    = ^r_data;
`else
                  w_state_d = StStop;
                  w_tx_d    = 1'b1;
`endif
               end else begin
                  w_bit_d = r_bit + 3'd1;
                  w_tx_d  = r_data[w_bit_d];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (w_bit_end) begin
               w_state_d = StStop;
               w_cnt_d   = '0;
               w_tx_d    = 1'b1;
            end
         end
`endif
         StStop: begin
            if (w_bit_end) begin
               w_cnt_d = '0;
               w_start = tx_en_i & ~w_empty;
               if (!w_start) begin
                  w_state_d = StIdle;
                  w_tx_d    = 1'b1;
               end
            end
         end
         default: begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
            w_tx_d    = 1'b1;
         end
      endcase

      // New frame: the divisor is latched here so mid-frame changes wait for the next frame.
      if (w_start) begin
         w_pop     = 1'b1;
         w_state_d = StStart;
         w_div_d   = div_i;
         w_cnt_d   = '0;
         w_data_d  = r_mem[r_rd_ptr];
         w_tx_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
         r_div   <= '0;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_data  <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_d;
         r_div   <= w_div_d;
         r_cnt   <= w_cnt_d;
         r_bit   <= w_bit_d;
         r_data  <= w_data_d;
         r_tx    <= w_tx_d;
      end
   end

   assign tx_o = r_tx;

   always_comb begin
      rdat_o      = '0;
      rdat_o[0]   = (r_state != StIdle);
      rdat_o[1]   = w_full;
      rdat_o[2]   = w_empty;
      rdat_o[7:3] = 5'(r_level);
   end

   assign rerr_o = 1'b0;

   // Status reads have no side effects; the strobe is accepted but not needed.
   assign w_unused = rreq_i;

endmodule
